// File: rtl/sc_lane_shift_ctrl_pkg.sv
// Shared types, shift codes and the LFSR step function for the lane shift controller.
package sc_lane_shift_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [1:0] SHIFT_HOLD = 2'b00;
    localparam logic [1:0] SHIFT_LEFT = 2'b10;

    // Fibonacci left shift, taps 7/5/4/3
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

endpackage

// File: rtl/sc_lane_shift_ctrl_if.sv
// Control/status bundle between the game control FSM (master) and the lane shift controller (slave).
interface sc_lane_shift_ctrl_if #(
    parameter int PRESCALE_WIDTH = 23
);
    logic                      SC_LaneCTRL_clear_InLow;
    logic                      SC_LaneCTRL_start_InLow;
    logic                      SC_LaneCTRL_pause_InLow;
    logic [PRESCALE_WIDTH-1:0] SC_LaneCTRL_period_InBUS;
    logic [1:0]                SC_LaneCTRL_shiftselection_Out;
    logic [3:0]                SC_LaneCTRL_random_OutBUS;
    logic                      SC_LaneCTRL_clear_OutLow;
    logic                      SC_LaneCTRL_running_Out;

    modport master (
        output SC_LaneCTRL_clear_InLow,
        output SC_LaneCTRL_start_InLow,
        output SC_LaneCTRL_pause_InLow,
        output SC_LaneCTRL_period_InBUS,
        input  SC_LaneCTRL_shiftselection_Out,
        input  SC_LaneCTRL_random_OutBUS,
        input  SC_LaneCTRL_clear_OutLow,
        input  SC_LaneCTRL_running_Out
    );

    modport slave (
        input  SC_LaneCTRL_clear_InLow,
        input  SC_LaneCTRL_start_InLow,
        input  SC_LaneCTRL_pause_InLow,
        input  SC_LaneCTRL_period_InBUS,
        output SC_LaneCTRL_shiftselection_Out,
        output SC_LaneCTRL_random_OutBUS,
        output SC_LaneCTRL_clear_OutLow,
        output SC_LaneCTRL_running_Out
    );

endinterface

// File: rtl/sc_lane_shift_ctrl_lfsr8.sv
// 8-bit pattern LFSR: loads SEED on reset or reseed, steps when enabled, self-recovers from all-zero.
module sc_lfsr8
    import sc_lane_shift_ctrl_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       reseed,
    output logic [7:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= SEED;
        end else if (reseed) begin
            q <= SEED;
        end else if (en) begin
            q <= (q == 8'h00) ? SEED : lfsr_next(q);
        end
    end

endmodule

// File: rtl/sc_lane_shift_ctrl.sv
// Lane scroll pacing: run/pause/idle FSM, period tick counter with one-clock shift strobes,
// restart clear pulse and a pseudo-random pattern nibble for the lane registers.
module sc_lane_shift_ctrl
    import sc_lane_shift_ctrl_pkg::*;
#(
    parameter int         PRESCALE_WIDTH = 23,
    parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
    input logic SC_RegBACKGTYPE_CLOCK_50,
    input logic SC_RegBACKGTYPE_RESET_InHigh,
    sc_lane_shift_ctrl_if.slave lane
);

    state_t                    state;
    state_t                    next_state;
    logic [PRESCALE_WIDTH-1:0] count;
    logic [PRESCALE_WIDTH-1:0] wrap_at;
    logic [1:0]                shift_sel;
    logic                      clear_pulse_n;
    logic                      running;
    logic [7:0]                lfsr_q;
    logic                      do_tick;
    logic                      do_restart;
    logic                      clear_req;
    logic                      start_req;
    logic                      pause_req;

    assign clear_req = ~lane.SC_LaneCTRL_clear_InLow;
    assign start_req = ~lane.SC_LaneCTRL_start_InLow;
    assign pause_req = ~lane.SC_LaneCTRL_pause_InLow;

    // period 0 and 1 both mean "strobe every clock"
    assign wrap_at = (lane.SC_LaneCTRL_period_InBUS < PRESCALE_WIDTH'(2))
                   ? '0
                   : lane.SC_LaneCTRL_period_InBUS - PRESCALE_WIDTH'(1);

    // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        do_tick    = 1'b0;
        do_restart = 1'b0;
        if (clear_req) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_req) begin
                        next_state = RUN;
                        do_restart = 1'b1;
                    end
                end
                RUN: begin
                    if (pause_req) next_state = PAUSE;
                    else           do_tick    = 1'b1;
                end
                PAUSE: begin
                    if (start_req && !pause_req) next_state = RUN;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge SC_RegBACKGTYPE_CLOCK_50 or posedge SC_RegBACKGTYPE_RESET_InHigh) begin
        if (SC_RegBACKGTYPE_RESET_InHigh) begin
            state         <= IDLE;
            count         <= '0;
            shift_sel     <= SHIFT_HOLD;
            clear_pulse_n <= 1'b1;
            running       <= 1'b0;
        end else begin
            state         <= next_state;
            running       <= (next_state == RUN);
            shift_sel     <= SHIFT_HOLD;
            clear_pulse_n <= 1'b1;
            if (clear_req || do_restart) begin
                count         <= '0;
                clear_pulse_n <= 1'b0;
            end else if (do_tick) begin
                // >= so a shrinking period wraps immediately instead of running to overflow
                if (count >= wrap_at) begin
                    count     <= '0;
                    shift_sel <= SHIFT_LEFT;
                end else begin
                    count <= count + PRESCALE_WIDTH'(1);
                end
            end
        end
    end

    // Step only after a strobe cycle so the nibble is stable while it is being sampled downstream.
    sc_lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk    (SC_RegBACKGTYPE_CLOCK_50),
        .rst    (SC_RegBACKGTYPE_RESET_InHigh),
        .en     ((shift_sel == SHIFT_LEFT) && !clear_req),
        .reseed (clear_req),
        .q      (lfsr_q)
    );

    assign lane.SC_LaneCTRL_shiftselection_Out = shift_sel;
    assign lane.SC_LaneCTRL_random_OutBUS      = lfsr_q[3:0];
    assign lane.SC_LaneCTRL_clear_OutLow       = clear_pulse_n;
    assign lane.SC_LaneCTRL_running_Out        = running;

endmodule
